// File: rtl/mel_mac_sched.sv
// ---------------------------------------------------------------------------
// mel_mac_sched
//
// Purpose:
//   Sequences the shared mel-filterbank MAC for one log-mel frame. After an
//   accepted start it walks N_MELS triangular bands. For each band it reads
//   the band-table ROM (start bin, length, coefficient base). It then issues
//   power-RAM / coefficient-ROM reads and drives the MAC clear and accumulate
//   strobes. The finished band energy is presented on a valid/ready stream
//   toward the log stage.
//
// Per-band timeline (mel_ready_i held high):
//   LOAD  -> WAIT -> RUN x eff_len -> DRAIN -> CAPTURE -> OUTPUT
//   This takes eff_len+5 cycles from LOAD to the handshake, inclusive.
//
// Ports:
//   clk_i, reset_i     clock, asynchronous active-high reset
//   start_i            frame start pulse (accepted only in IDLE, not on done)
//   busy_o             high from the cycle after an accepted start through done
//   done_o             one-cycle pulse after the last band handshake
//   err_o              sticky band-overrun flag, cleared by an accepted start
//   band_addr_o        band-table ROM address (current band)
//   band_start_i       band first bin        (1-cycle ROM latency)
//   band_len_i         band length in bins   (1-cycle ROM latency)
//   band_coef_i        band coefficient base (1-cycle ROM latency)
//   power_addr_o       power RAM read address (1-cycle RAM latency)
//   coef_addr_o        coefficient ROM read address (1-cycle ROM latency)
//   mac_clear_o        MAC clear strobe (LOAD only)
//   mac_accumulate_o   MAC accumulate strobe (one cycle after each issue)
//   mac_accum_i        MAC accumulator value
//   mel_valid_o        band energy valid
//   mel_ready_i        downstream ready
//   mel_data_o         band energy
//   mel_idx_o          band index of mel_data_o
// ---------------------------------------------------------------------------
module mel_mac_sched #(
  parameter int N_BINS  = 257,
  parameter int N_MELS  = 40,
  parameter int BIN_AW  = 9,
  parameter int COEF_AW = 11,
  parameter int BAND_AW = 6,
  parameter int ACCUM_W = 54
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic [BAND_AW-1:0] band_addr_o,
  input  logic [BIN_AW-1:0]  band_start_i,
  input  logic [BIN_AW-1:0]  band_len_i,
  input  logic [COEF_AW-1:0] band_coef_i,
  output logic [BIN_AW-1:0]  power_addr_o,
  output logic [COEF_AW-1:0] coef_addr_o,
  output logic               mac_clear_o,
  output logic               mac_accumulate_o,
  input  logic [ACCUM_W-1:0] mac_accum_i,
  output logic               mel_valid_o,
  input  logic               mel_ready_i,
  output logic [ACCUM_W-1:0] mel_data_o,
  output logic [BAND_AW-1:0] mel_idx_o
);

  // One extra bit so N_BINS - start and the clamped length never wrap.
  localparam int                EXT_W   = BIN_AW + 1;
  localparam logic [EXT_W-1:0]  NB_EXT  = EXT_W'(N_BINS);
  localparam logic [BAND_AW-1:0] LAST_BAND = BAND_AW'(N_MELS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_RUN,
    S_DRAIN,
    S_CAPTURE,
    S_OUTPUT
  } state_e;

  state_e state_q, state_d;

  logic [BAND_AW-1:0] band_cnt_q, band_cnt_d;
  logic [BIN_AW-1:0]  pwr_addr_q, pwr_addr_d;
  logic [COEF_AW-1:0] coef_addr_q, coef_addr_d;
  logic [EXT_W-1:0]   rem_q, rem_d;
  logic               acc_pipe_q, acc_pipe_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [ACCUM_W-1:0] mel_data_q, mel_data_d;
  logic [BAND_AW-1:0] mel_idx_q, mel_idx_d;

  // -------------------------------------------------------------------------
  // Band length clamp. A band that starts at or past N_BINS has nothing
  // available. A band that would run past the last bin is shortened to the
  // available bins and flagged as an overrun.
  // -------------------------------------------------------------------------
  logic [EXT_W-1:0] start_ext;
  logic [EXT_W-1:0] len_ext;
  logic [EXT_W-1:0] avail;
  logic [EXT_W-1:0] eff_len;
  logic             overrun;

  assign start_ext = {1'b0, band_start_i};
  assign len_ext   = {1'b0, band_len_i};
  assign avail     = (start_ext >= NB_EXT) ? '0 : (NB_EXT - start_ext);
  assign overrun   = (len_ext > avail);
  assign eff_len   = overrun ? avail : len_ext;

  logic start_accept;
  logic handshake;
  logic last_band;
  logic last_issue;

  // A start in the done cycle is ignored, even though the FSM is in IDLE.
  assign start_accept = (state_q == S_IDLE) && start_i && !done_q;
  assign handshake    = (state_q == S_OUTPUT) && mel_ready_i;
  assign last_band    = (band_cnt_q == LAST_BAND);
  assign last_issue   = (rem_q == EXT_W'(1));

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_accept) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A zero-length band still passes through DRAIN (with an empty
        // accumulate pipe). Every band therefore costs eff_len+5 cycles.
        if (eff_len == '0) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (last_issue) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        state_d = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (mel_ready_i) begin
          state_d = last_band ? S_IDLE : S_LOAD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    band_cnt_d  = band_cnt_q;
    pwr_addr_d  = pwr_addr_q;
    coef_addr_d = coef_addr_q;
    rem_d       = rem_q;
    err_d       = err_q;
    mel_data_d  = mel_data_q;
    mel_idx_d   = mel_idx_q;
    // Read data returns one cycle after its issue, so the accumulate strobe
    // is simply the RUN flag delayed by one cycle.
    acc_pipe_d  = (state_q == S_RUN);
    done_d      = handshake && last_band;

    case (state_q)
      S_IDLE: begin
        if (start_accept) begin
          err_d      = 1'b0;
          band_cnt_d = '0;
        end
      end
      S_WAIT: begin
        pwr_addr_d  = band_start_i;
        coef_addr_d = band_coef_i;
        rem_d       = eff_len;
        if (overrun) begin
          err_d = 1'b1;
        end
      end
      S_RUN: begin
        rem_d = rem_q - EXT_W'(1);
        // Hold the addresses on the last issue so they never step past the
        // final bin of the band.
        if (!last_issue) begin
          pwr_addr_d  = pwr_addr_q + BIN_AW'(1);
          coef_addr_d = coef_addr_q + COEF_AW'(1);
        end
      end
      S_CAPTURE: begin
        mel_data_d = mac_accum_i;
        mel_idx_d  = band_cnt_q;
      end
      S_OUTPUT: begin
        if (mel_ready_i && !last_band) begin
          band_cnt_d = band_cnt_q + BAND_AW'(1);
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      band_cnt_q  <= '0;
      pwr_addr_q  <= '0;
      coef_addr_q <= '0;
      rem_q       <= '0;
      acc_pipe_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mel_data_q  <= '0;
      mel_idx_q   <= '0;
    end else begin
      band_cnt_q  <= band_cnt_d;
      pwr_addr_q  <= pwr_addr_d;
      coef_addr_q <= coef_addr_d;
      rem_q       <= rem_d;
      acc_pipe_q  <= acc_pipe_d;
      done_q      <= done_d;
      err_q       <= err_d;
      mel_data_q  <= mel_data_d;
      mel_idx_q   <= mel_idx_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: output logic
  // -------------------------------------------------------------------------
  always_comb begin
    // busy stays high through the done cycle, when the FSM is back in IDLE.
    busy_o           = (state_q != S_IDLE) || done_q;
    done_o           = done_q;
    err_o            = err_q;
    band_addr_o      = band_cnt_q;
    power_addr_o     = pwr_addr_q;
    coef_addr_o      = coef_addr_q;
    mac_clear_o      = (state_q == S_LOAD);
    mac_accumulate_o = acc_pipe_q;
    mel_valid_o      = (state_q == S_OUTPUT);
    mel_data_o       = mel_data_q;
    mel_idx_o        = mel_idx_q;
  end

endmodule

// File: tb/tb_mel_mac_sched.sv
// ---------------------------------------------------------------------------
// tb_mel_mac_sched
//
// Directed bench for mel_mac_sched. It provides a band-table ROM, a power
// RAM (power[i] = i) and a constant coefficient ROM (2). All three have a
// 1-cycle read latency. A MAC model completes the loop. The expected band
// energy is therefore 2 * sum(issued bins).
// ---------------------------------------------------------------------------
module tb_mel_mac_sched;

  localparam int BIN_AW  = 9;
  localparam int COEF_AW = 11;
  localparam int BAND_AW = 6;
  localparam int ACCUM_W = 54;

  logic               clk = 1'b0;
  logic               reset_i;
  logic               start_i;
  logic               busy_o;
  logic               done_o;
  logic               err_o;
  logic [BAND_AW-1:0] band_addr_o;
  logic [BIN_AW-1:0]  band_start_i;
  logic [BIN_AW-1:0]  band_len_i;
  logic [COEF_AW-1:0] band_coef_i;
  logic [BIN_AW-1:0]  power_addr_o;
  logic [COEF_AW-1:0] coef_addr_o;
  logic               mac_clear_o;
  logic               mac_accumulate_o;
  logic [ACCUM_W-1:0] mac_accum_i;
  logic               mel_valid_o;
  logic               mel_ready_i;
  logic [ACCUM_W-1:0] mel_data_o;
  logic [BAND_AW-1:0] mel_idx_o;

  mel_mac_sched dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .start_i          (start_i),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .err_o            (err_o),
    .band_addr_o      (band_addr_o),
    .band_start_i     (band_start_i),
    .band_len_i       (band_len_i),
    .band_coef_i      (band_coef_i),
    .power_addr_o     (power_addr_o),
    .coef_addr_o      (coef_addr_o),
    .mac_clear_o      (mac_clear_o),
    .mac_accumulate_o (mac_accumulate_o),
    .mac_accum_i      (mac_accum_i),
    .mel_valid_o      (mel_valid_o),
    .mel_ready_i      (mel_ready_i),
    .mel_data_o       (mel_data_o),
    .mel_idx_o        (mel_idx_o)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int busy_cnt   = 0;
  int done_cnt   = 0;

  logic [BIN_AW-1:0]  st_tab [64];
  logic [BIN_AW-1:0]  ln_tab [64];
  logic [COEF_AW-1:0] cf_tab [64];
  logic [BIN_AW-1:0]  pd_q;
  logic [ACCUM_W-1:0] acc_model = '0;

  assign mac_accum_i = acc_model;

  // Band ROM, power RAM and MAC models.
  always @(posedge clk) begin
    band_start_i <= st_tab[band_addr_o];
    band_len_i   <= ln_tab[band_addr_o];
    band_coef_i  <= cf_tab[band_addr_o];
    pd_q         <= power_addr_o;
    if (mac_clear_o) begin
      acc_model <= '0;
    end else if (mac_accumulate_o) begin
      acc_model <= acc_model + ACCUM_W'(pd_q) * 2;
    end
  end

  always @(negedge clk) begin
    if (busy_o) busy_cnt = busy_cnt + 1;
    if (done_o) done_cnt = done_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_flags"}, {60'd0, busy_o, done_o, err_o, mac_clear_o} |
                           {62'd0, mac_accumulate_o, mel_valid_o}, 64'd0);
    check({tag, "_addrs"}, {band_addr_o, power_addr_o, coef_addr_o}, 64'd0);
    check({tag, "_data"}, mel_data_o, 64'd0);
    check({tag, "_idx"}, mel_idx_o, 64'd0);
  endtask

  // Follows one band from its LOAD cycle through its handshake. The ready
  // input is held low for 'hold' cycles once the band is valid.
  task automatic do_band(input int idx, input int eff, input longint data,
                         input int hold, input bit last);
    int guard;
    int cyc;
    int accs;
    guard = 0;
    while (mac_clear_o !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    check("load_clear", mac_clear_o, 1);
    check("band_addr", band_addr_o, idx);
    mel_ready_i = (hold == 0);
    cyc  = 0;
    accs = 0;
    while (mel_valid_o !== 1'b1 && guard < 600) begin
      check("clear_acc_excl", mac_clear_o & mac_accumulate_o, 0);
      cyc++;
      accs += int'(mac_accumulate_o);
      tick();
      guard++;
    end
    check("valid_seen", mel_valid_o, 1);
    check("pre_out_cycles", cyc, eff + 4);
    check("acc_strobes", accs, eff);
    check("mel_idx", mel_idx_o, idx);
    check("mel_data", mel_data_o, data);
    for (int h = 0; h < hold; h++) begin
      tick();
      check("bp_valid", mel_valid_o, 1);
      check("bp_idx", mel_idx_o, idx);
      check("bp_data", mel_data_o, data);
      check("bp_strobes", {mac_clear_o, mac_accumulate_o}, 0);
    end
    mel_ready_i = 1'b1;
    tick();
    check("valid_drop", mel_valid_o, 0);
    check("done_pulse", done_o, last);
    if (!last) check("next_load", mac_clear_o, 1);
  endtask

  task automatic load_uniform_table();
    for (int i = 0; i < 64; i++) begin
      st_tab[i] = BIN_AW'(4 * i);
      ln_tab[i] = BIN_AW'(4);
      cf_tab[i] = COEF_AW'(8 * i);
    end
  endtask

  task automatic run_uniform_frame(input string tag);
    int bc0;
    int dc0;
    bc0 = busy_cnt;
    dc0 = done_cnt;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check({tag, "_err_cleared"}, err_o, 0);
    for (int i = 0; i < 40; i++) begin
      do_band(i, 4, longint'(32 * i + 12), 0, (i == 39));
    end
    tick();
    check({tag, "_busy_cycles"}, busy_cnt - bc0, 361);
    check({tag, "_done_count"}, done_cnt - dc0, 1);
    check({tag, "_idle"}, busy_o, 0);
  endtask

  initial begin
    int dc;
    reset_i     = 1'b1;
    start_i     = 1'b0;
    mel_ready_i = 1'b1;

    // Frame A: special bands 0..4, uniform bands after that.
    load_uniform_table();
    st_tab[0] = 9'd10;  ln_tab[0] = 9'd3; cf_tab[0] = 11'd100;
    st_tab[1] = 9'd20;  ln_tab[1] = 9'd4; cf_tab[1] = 11'd200;
    st_tab[2] = 9'd30;  ln_tab[2] = 9'd2; cf_tab[2] = 11'd300;
    st_tab[3] = 9'd0;   ln_tab[3] = 9'd0; cf_tab[3] = 11'd0;
    st_tab[4] = 9'd255; ln_tab[4] = 9'd5; cf_tab[4] = 11'd400;

    tick();
    tick();
    check_outputs_zero("reset");
    reset_i = 1'b0;
    tick();

    // Band 0 cycle by cycle: start=10, len=3, coef=100.
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("b0_load_clear", mac_clear_o, 1);
    check("b0_busy", busy_o, 1);
    check("b0_load_acc", mac_accumulate_o, 0);
    tick();
    check("b0_wait_strobes", {mac_clear_o, mac_accumulate_o}, 0);
    tick();
    check("b0_issue0", {power_addr_o, coef_addr_o, mac_accumulate_o}, {9'd10, 11'd100, 1'b0});
    tick();
    check("b0_issue1", {power_addr_o, coef_addr_o, mac_accumulate_o}, {9'd11, 11'd101, 1'b1});
    tick();
    check("b0_issue2", {power_addr_o, coef_addr_o, mac_accumulate_o}, {9'd12, 11'd102, 1'b1});
    tick();
    check("b0_drain_acc", {mac_clear_o, mac_accumulate_o}, 2'b01);
    tick();
    check("b0_capture", {mac_accumulate_o, mel_valid_o}, 2'b00);
    tick();
    check("b0_valid", mel_valid_o, 1);
    check("b0_idx", mel_idx_o, 0);
    check("b0_data", mel_data_o, 66);
    tick();
    check("b0_valid_drop", mel_valid_o, 0);
    check("b0_no_done", done_o, 0);

    do_band(1, 4, 172, 0, 1'b0);
    do_band(2, 2, 122, 7, 1'b0);   // backpressure
    do_band(3, 0, 0, 0, 1'b0);     // zero-length
    check("err_before_overrun", err_o, 0);
    do_band(4, 2, 1022, 0, 1'b0);  // overrun: only bins 255, 256
    check("err_after_overrun", err_o, 1);
    for (int i = 5; i < 40; i++) begin
      do_band(i, 4, longint'(32 * i + 12), 0, (i == 39));
    end

    // Start in the done cycle must be ignored.
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("done_start_ignored", busy_o, 0);
    check("err_sticky", err_o, 1);

    // Frame B: 40 uniform bands.
    load_uniform_table();
    run_uniform_frame("frameB");

    // Reset in the middle of RUN.
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    tick();
    check("pre_reset_acc", mac_accumulate_o, 1);
    #2;
    reset_i = 1'b1;
    #1;
    check_outputs_zero("async_reset");
    dc = done_cnt;
    tick();
    tick();
    reset_i = 1'b0;
    tick();
    tick();
    tick();
    check("no_done_after_abort", done_cnt - dc, 0);
    check("idle_after_abort", busy_o, 0);
    run_uniform_frame("frameC");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
